// File: rtl/lsu.sv
// Load/store unit: turns EX/MEM load/store requests into single-beat data-bus
// transactions, with store lane formatting and load extraction/extension.
module lsu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex2mem_mem_rd,
    input  logic        ex2mem_mem_wr,
    input  logic [31:0] ex2mem_alu_out,
    input  logic [31:0] ex2mem_mem_wdata,
    input  logic [2:0]  ex2mem_funct3,
    output logic [31:0] lsu_rdata,
    output logic        lsu_stall,
    output logic        lsu_load_misaligned,
    output logic        lsu_store_misaligned,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ready,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t      state_reg;
    logic        bus_req_reg;
    logic        bus_we_reg;
    logic [31:0] bus_addr_reg;
    logic [31:0] bus_wdata_reg;
    logic [3:0]  bus_be_reg;
    logic [31:0] lsu_rdata_reg;
    logic [2:0]  funct3_reg;
    logic [1:0]  addr_lo_reg;

    // Request decode; a simultaneous read and write is treated as a read.
    logic is_load;
    logic is_store;
    logic load_f3_ok;
    logic store_f3_ok;
    logic is_byte;
    logic is_half;
    logic is_word;
    logic misaligned;
    logic in_idle;
    logic access_ok;

    assign is_load     = ex2mem_mem_rd;
    assign is_store    = ex2mem_mem_wr & ~ex2mem_mem_rd;
    assign load_f3_ok  = (ex2mem_funct3 == 3'd0) || (ex2mem_funct3 == 3'd1) ||
                         (ex2mem_funct3 == 3'd2) || (ex2mem_funct3 == 3'd4) ||
                         (ex2mem_funct3 == 3'd5);
    assign store_f3_ok = (ex2mem_funct3 == 3'd0) || (ex2mem_funct3 == 3'd1) ||
                         (ex2mem_funct3 == 3'd2);
    assign is_byte     = (ex2mem_funct3[1:0] == 2'd0);
    assign is_half     = (ex2mem_funct3[1:0] == 2'd1);
    assign is_word     = (ex2mem_funct3[1:0] == 2'd2);
    assign misaligned  = (is_half & ex2mem_alu_out[0]) |
                         (is_word & (ex2mem_alu_out[1:0] != 2'b00));
    assign in_idle     = (state_reg == ST_IDLE);

    assign access_ok = in_idle & ~misaligned &
                       ((is_load & load_f3_ok) | (is_store & store_f3_ok));

    assign lsu_load_misaligned  = in_idle & is_load  & load_f3_ok  & misaligned;
    assign lsu_store_misaligned = in_idle & is_store & store_f3_ok & misaligned;
    assign lsu_stall            = access_ok | (state_reg == ST_REQ) | (state_reg == ST_WAIT);

    // Store lane formatting: each lane takes its own byte, its half's byte, or byte 0.
    logic [3:0]  st_be;
    logic [31:0] st_wdata;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign st_be[gi] = is_word |
                               (is_half & (ex2mem_alu_out[1] == LANE[1])) |
                               (is_byte & (ex2mem_alu_out[1:0] == LANE));
            assign st_wdata[8*gi +: 8] = is_word ? ex2mem_mem_wdata[8*gi +: 8] :
                                         is_half ? ex2mem_mem_wdata[8*(gi%2) +: 8] :
                                                   ex2mem_mem_wdata[7:0];
        end
    endgenerate

    // Load extraction uses the address/width captured at request time.
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    always_comb begin
        ld_byte = 8'h00;
        case (addr_lo_reg)
            2'd0: ld_byte = bus_rdata[7:0];
            2'd1: ld_byte = bus_rdata[15:8];
            2'd2: ld_byte = bus_rdata[23:16];
            2'd3: ld_byte = bus_rdata[31:24];
            default: ld_byte = 8'h00;
        endcase
    end

    assign ld_half = addr_lo_reg[1] ? bus_rdata[31:16] : bus_rdata[15:0];

    always_comb begin
        ld_data = bus_rdata;
        case (funct3_reg)
            3'd0:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'd4:    ld_data = {24'h000000, ld_byte};
            3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
            3'd5:    ld_data = {16'h0000, ld_half};
            default: ld_data = bus_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            bus_req_reg   <= 1'b0;
            bus_we_reg    <= 1'b0;
            bus_addr_reg  <= 32'h0;
            bus_wdata_reg <= 32'h0;
            bus_be_reg    <= 4'h0;
            lsu_rdata_reg <= 32'h0;
            funct3_reg    <= 3'd0;
            addr_lo_reg   <= 2'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (access_ok) begin
                        state_reg     <= ST_REQ;
                        bus_req_reg   <= 1'b1;
                        bus_we_reg    <= is_store;
                        bus_addr_reg  <= {ex2mem_alu_out[31:2], 2'b00};
                        bus_wdata_reg <= st_wdata;
                        bus_be_reg    <= is_store ? st_be : 4'hF;
                        funct3_reg    <= ex2mem_funct3;
                        addr_lo_reg   <= ex2mem_alu_out[1:0];
                    end
                end
                ST_REQ: begin
                    // Any rvalid arriving alongside ready is deliberately not looked at here.
                    if (bus_ready) begin
                        bus_req_reg <= 1'b0;
                        state_reg   <= bus_we_reg ? ST_DONE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus_rvalid) begin
                        lsu_rdata_reg <= ld_data;
                        state_reg     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg   <= ST_IDLE;
                    bus_req_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus_req   = bus_req_reg;
    assign bus_we    = bus_we_reg;
    assign bus_addr  = bus_addr_reg;
    assign bus_wdata = bus_wdata_reg;
    assign bus_be    = bus_be_reg;
    assign lsu_rdata = lsu_rdata_reg;

endmodule

// File: tb/tb_lsu.sv
// Directed and randomized checks of lsu against an arithmetic reference model.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex2mem_mem_rd = 1'b0;
    logic        ex2mem_mem_wr = 1'b0;
    logic [31:0] ex2mem_alu_out = 32'h0;
    logic [31:0] ex2mem_mem_wdata = 32'h0;
    logic [2:0]  ex2mem_funct3 = 3'd0;
    logic [31:0] lsu_rdata;
    logic        lsu_stall;
    logic        lsu_load_misaligned;
    logic        lsu_store_misaligned;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ready = 1'b0;
    logic        bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = 32'h0;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_lsu = 32'h0;

    lsu dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .ex2mem_mem_rd        (ex2mem_mem_rd),
        .ex2mem_mem_wr        (ex2mem_mem_wr),
        .ex2mem_alu_out       (ex2mem_alu_out),
        .ex2mem_mem_wdata     (ex2mem_mem_wdata),
        .ex2mem_funct3        (ex2mem_funct3),
        .lsu_rdata            (lsu_rdata),
        .lsu_stall            (lsu_stall),
        .lsu_load_misaligned  (lsu_load_misaligned),
        .lsu_store_misaligned (lsu_store_misaligned),
        .bus_req              (bus_req),
        .bus_we               (bus_we),
        .bus_addr             (bus_addr),
        .bus_wdata            (bus_wdata),
        .bus_be               (bus_be),
        .bus_ready            (bus_ready),
        .bus_rvalid           (bus_rvalid),
        .bus_rdata            (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int acc_size(input logic [2:0] f3);
        return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit f3_legal(input bit ld, input logic [2:0] f3);
        if (ld) return (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
        return (f3 == 0) || (f3 == 1) || (f3 == 2);
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] word);
        logic [31:0] v;
        v = word >> (8 * (addr % 4));
        case (f3)
            3'd0: begin v = v & 32'hFF;   if (v >= 32'h80)   v = v + 32'hFFFFFF00; end
            3'd4: v = v & 32'hFF;
            3'd1: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v + 32'hFFFF0000; end
            3'd5: v = v & 32'hFFFF;
            default: v = word;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        if (acc_size(f3) == 1) return (wd & 32'hFF) * 32'h01010101;
        if (acc_size(f3) == 2) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    task automatic cycle;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ex_idle;
        ex2mem_mem_rd = 1'b0;
        ex2mem_mem_wr = 1'b0;
    endtask

    // Runs one EX request from IDLE through DONE; entered and left just after a negedge.
    task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [2:0] f3,
                          input int rdy_dly, input int rv_dly,
                          input logic [31:0] rword, input bit bogus_rv);
        bit          ld, st, legal, aligned, valid;
        logic [31:0] e_be, e_addr, e_wd;
        ld      = rd;
        st      = wr && !rd;
        legal   = (ld || st) && f3_legal(ld, f3);
        aligned = (addr % acc_size(f3)) == 0;
        valid   = legal && aligned;
        e_addr  = addr - (addr % 4);
        e_be    = ld ? 32'hF : (((32'd1 << acc_size(f3)) - 1) << (addr % 4));
        e_wd    = model_wdata(f3, wd);

        ex2mem_mem_rd = rd; ex2mem_mem_wr = wr;
        ex2mem_alu_out = addr; ex2mem_mem_wdata = wd; ex2mem_funct3 = f3;
        #1;
        $display("txn rd=%0d wr=%0d f3=%0d addr=%h wd=%h valid=%0d", rd, wr, f3, addr, wd, valid);
        check("idle_stall", {31'b0, lsu_stall}, {31'b0, valid});
        check("load_mis", {31'b0, lsu_load_misaligned}, {31'b0, ld && legal && !aligned});
        check("store_mis", {31'b0, lsu_store_misaligned}, {31'b0, st && legal && !aligned});
        cycle();
        if (!valid) begin
            ex_idle();
            #1;
            check("no_req", {31'b0, bus_req}, 32'd0);
            check("rdata_hold", lsu_rdata, exp_lsu);
            return;
        end

        // REQ: scramble the EX inputs to prove the request was latched.
        ex_idle();
        ex2mem_alu_out = $urandom; ex2mem_mem_wdata = $urandom; ex2mem_funct3 = 3'($urandom);
        for (int i = 0; i <= rdy_dly; i++) begin
            check("req", {31'b0, bus_req}, 32'd1);
            check("req_stall", {31'b0, lsu_stall}, 32'd1);
            check("req_we", {31'b0, bus_we}, {31'b0, st});
            check("req_addr", bus_addr, e_addr);
            check("req_be", {28'b0, bus_be}, e_be);
            if (st) check("req_wdata", bus_wdata, e_wd);
            if (i == rdy_dly) begin
                bus_ready = 1'b1;
                if (bogus_rv) begin bus_rvalid = 1'b1; bus_rdata = ~rword; end
            end
            cycle();
        end
        bus_ready = 1'b0; bus_rvalid = 1'b0;

        if (ld) begin
            for (int i = 0; i <= rv_dly; i++) begin
                check("wait_req", {31'b0, bus_req}, 32'd0);
                check("wait_stall", {31'b0, lsu_stall}, 32'd1);
                if (i == rv_dly) begin bus_rvalid = 1'b1; bus_rdata = rword; end
                cycle();
            end
            bus_rvalid = 1'b0;
            exp_lsu = model_load(f3, addr, rword);
        end

        // DONE: a fresh valid request must not raise the stall.
        ex2mem_mem_rd = 1'b1; ex2mem_funct3 = 3'd2; ex2mem_alu_out = 32'h500;
        #1;
        check("done_stall", {31'b0, lsu_stall}, 32'd0);
        check("done_req", {31'b0, bus_req}, 32'd0);
        check("done_rdata", lsu_rdata, exp_lsu);
        cycle();
        check("post_done_req", {31'b0, bus_req}, 32'd0);
        ex_idle();
        #1;
    endtask

    initial begin
        bit          r, w;
        logic [2:0]  f3;
        logic [31:0] a;

        @(negedge clk);
        @(negedge clk);
        check("rst_req", {31'b0, bus_req}, 32'd0);
        check("rst_we", {31'b0, bus_we}, 32'd0);
        check("rst_be", {28'b0, bus_be}, 32'd0);
        check("rst_addr", bus_addr, 32'd0);
        check("rst_wdata", bus_wdata, 32'd0);
        check("rst_rdata", lsu_rdata, 32'd0);
        check("rst_stall", {31'b0, lsu_stall}, 32'd0);
        rst_n = 1'b1;
        cycle();

        access(1, 0, 32'h100, 32'h0, 3'd2, 0, 0, 32'hDEADBEEF, 0);
        check("lw_value", lsu_rdata, 32'hDEADBEEF);
        access(1, 0, 32'h103, 32'h0, 3'd0, 0, 0, 32'h80112233, 0);
        check("lb_value", lsu_rdata, 32'hFFFFFF80);
        access(1, 0, 32'h103, 32'h0, 3'd4, 0, 0, 32'h80112233, 0);
        check("lbu_value", lsu_rdata, 32'h00000080);
        access(1, 0, 32'h102, 32'h0, 3'd5, 0, 0, 32'h80112233, 0);
        check("lhu_value", lsu_rdata, 32'h00008011);
        access(0, 1, 32'h201, 32'h000000A5, 3'd0, 0, 0, 32'h0, 0);
        access(0, 1, 32'h202, 32'h00001234, 3'd1, 0, 0, 32'h0, 0);
        check("sh_be_const", {28'b0, bus_be}, 32'hC);
        access(1, 0, 32'h102, 32'h0, 3'd2, 0, 0, 32'h0, 0);
        access(0, 1, 32'h301, 32'h0, 3'd1, 0, 0, 32'h0, 0);
        access(0, 1, 32'h300, 32'h0, 3'd4, 0, 0, 32'h0, 0);
        access(1, 0, 32'h104, 32'h0, 3'd2, 5, 2, 32'h13579BDF, 1);

        for (int n = 0; n < 150; n++) begin
            r  = 1'($urandom);
            w  = 1'($urandom);
            f3 = 3'($urandom);
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a = a - (a % acc_size(f3));
            access(r, w, a, $urandom, f3, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom, 1'($urandom));
        end

        // Reset in WAIT drops everything; a late rvalid is ignored.
        access(1, 0, 32'h104, 32'h0, 3'd2, 0, 0, 32'hCAFEF00D, 0);
        ex2mem_mem_rd = 1'b1; ex2mem_funct3 = 3'd2; ex2mem_alu_out = 32'h400;
        cycle();
        ex_idle();
        check("rst2_req", {31'b0, bus_req}, 32'd1);
        bus_ready = 1'b1;
        cycle();
        bus_ready = 1'b0;
        check("rst2_wait_stall", {31'b0, lsu_stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        exp_lsu = 32'h0;
        check("rst_wait_req", {31'b0, bus_req}, 32'd0);
        check("rst_wait_stall", {31'b0, lsu_stall}, 32'd0);
        check("rst_wait_rdata", lsu_rdata, 32'd0);
        check("rst_wait_be", {28'b0, bus_be}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus_rvalid = 1'b1; bus_rdata = 32'h11223344;
        cycle();
        bus_rvalid = 1'b0;
        check("late_rv_rdata", lsu_rdata, 32'd0);
        check("late_rv_req", {31'b0, bus_req}, 32'd0);
        check("late_rv_stall", {31'b0, lsu_stall}, 32'd0);

        // Reset while in REQ drops bus_req without a clock edge.
        ex2mem_mem_rd = 1'b1; ex2mem_funct3 = 3'd2; ex2mem_alu_out = 32'h600;
        cycle();
        ex_idle();
        check("rst3_req", {31'b0, bus_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_req_drop", {31'b0, bus_req}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        access(1, 0, 32'h10E, 32'h0, 3'd1, 1, 1, 32'h9ABC0000, 0);
        check("final_lh", lsu_rdata, 32'hFFFF9ABC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 The block SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-002 Ports (name, direction, width, meaning):
- clk  in  1  core clock
- rst_n  in  1  async active-low reset
- ex2mem_mem_rd  in  1  load request from EX/MEM pipe
- ex2mem_mem_wr  in  1  store request from EX/MEM pipe
- ex2mem_alu_out  in  32  byte address
- ex2mem_mem_wdata  in  32  store data (rs2)
- ex2mem_funct3  in  3  width/sign: 0 B, 1 H, 2 W, 4 BU, 5 HU
- lsu_rdata  out  32  formatted load data to MEM stage
- lsu_stall  out  1  hold pipeline
- lsu_load_misaligned  out  1  misaligned load flag
- lsu_store_misaligned  out  1  misaligned store flag
- bus_req  out  1  data-bus request
- bus_we  out  1  write strobe
- bus_addr  out  32  word-aligned address, bits [1:0] = 0
- bus_wdata  out  32  lane-replicated write data
- bus_be  out  4  byte enables
- bus_ready  in  1  request accepted
- bus_rvalid  in  1  read data valid
- bus_rdata  in  32  read data

Function
REQ-003 FSM states: IDLE, REQ, WAIT, DONE.
REQ-004 An access is valid in IDLE when rd or wr is high, funct3 is legal (loads 0,1,2,4,5; stores 0,1,2) and the address is aligned; if rd and wr are both high, rd wins.
REQ-005 IDLE + valid access: latch address, funct3, formatted wdata/be, rd/wr; next state REQ; lsu_stall=1 that cycle.
REQ-006 REQ: bus_req=1 with all bus outputs stable; on bus_ready: write -> DONE, read -> WAIT; otherwise stay in REQ.
REQ-007 WAIT: bus_req=0; on bus_rvalid: register formatted bus_rdata into lsu_rdata, next state DONE. A bus_rvalid in the same cycle as bus_ready SHALL NOT be accepted.
REQ-008 DONE: lsu_stall=0 and the EX inputs are ignored; next state IDLE.
REQ-009 lsu_stall SHALL be 1 in REQ and WAIT, and in IDLE when a valid access is presented; 0 otherwise.
REQ-010 Alignment: H/HU/SH require addr[0]=0; W/SW require addr[1:0]=0.
- On violation in IDLE: the matching misaligned flag is 1 combinationally, no bus request, lsu_stall=0, and the state stays IDLE.
REQ-011 An illegal funct3 SHALL produce no bus access, no flag and no stall.
REQ-012 Store formatting:
- SB: be=0001<<addr[1:0], wdata = byte replicated x4.
- SH: be=0011 (addr[1]=0) or 1100, wdata = half replicated x2.
- SW: be=1111.
REQ-013 Load formatting:
- B/BU: select byte addr[1:0], sign-/zero-extend.
- H/HU: select half addr[1], sign-/zero-extend.
- W: pass through.
- bus_be=1111 for all loads.
REQ-014 lsu_rdata SHALL hold its value until the next load completes; stores SHALL NOT modify it.
REQ-015 Minimum latency with zero-wait bus: store 2 stall cycles + DONE; load 3 stall cycles + DONE.

Reset
REQ-016 Reset SHALL set: state=IDLE, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, lsu_rdata=0.
REQ-017 Reset asserted mid-transaction SHALL drop bus_req asynchronously and abandon the access; a later bus_rvalid SHALL be ignored in IDLE.
REQ-018 Misaligned flags and lsu_stall are combinational and SHALL follow REQ-009/REQ-010 in IDLE.

Verification
REQ-019 LW addr 0x100, bus_ready next cycle, bus_rvalid 1 cycle later with rdata 0xDEADBEEF -> bus_addr 0x100, be 1111, lsu_rdata 0xDEADBEEF in DONE, stall high for 3 cycles.
REQ-020 LB addr 0x103 with rdata 0x80112233 -> lsu_rdata 0xFFFFFF80; LBU -> 0x00000080; LHU addr 0x102 -> 0x00008011.
REQ-021 SB addr 0x201 wdata 0x000000A5 -> bus_addr 0x200, be 0010, wdata 0xA5A5A5A5, we=1; SH addr 0x202 wdata 0x1234 -> be 1100, wdata 0x12341234.
REQ-022 LW addr 0x102 -> lsu_load_misaligned=1, bus_req never asserted, stall 0; SH addr 0x301 -> lsu_store_misaligned=1.
REQ-023 bus_ready held low 5 cycles in REQ -> bus_req and bus outputs constant and stall=1 throughout; then completes normally.
REQ-024 rst_n low while in WAIT, then bus_rvalid -> bus_req=0 immediately, state IDLE, lsu_rdata=0, and the rvalid has no effect.
